// File: rtl/iterative_alu.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle logic/arith/shift/compare ops
// and iterative unsigned multiply (shift-add) and divide/remainder (restoring), one step per cycle.
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;
    localparam logic [3:0] OP_NOR  = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [SHW-1:0]   cnt_reg;
    logic [WIDTH-1:0] a_reg, b_reg, acc_reg, quo_reg;
    logic [3:0]       op_reg;

    logic             accept, div_op, is_iter;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] single_result;
    logic [WIDTH-1:0] mul_step, rem_step, quo_step, acc_step, iter_result;
    logic [WIDTH:0]   rem_shift, rem_sub;
    logic             rem_ge;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;
    assign div_op    = (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);
    // Divide by zero is resolved immediately, so only a real divide iterates.
    assign is_iter   = (ALUControl == OP_MUL) || (div_op && (B != '0));
    assign shamt     = B[SHW-1:0];

    always_comb begin
        single_result = '0;
        case (ALUControl)
            OP_AND:  single_result = A & B;
            OP_OR:   single_result = A | B;
            OP_ADD:  single_result = A + B;
            OP_SUB:  single_result = A - B;
            OP_SLT:  single_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: single_result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_XOR:  single_result = A ^ B;
            OP_SLL:  single_result = A << shamt;
            OP_SRL:  single_result = A >> shamt;
            OP_SRA:  single_result = $unsigned($signed(A) >>> shamt);
            OP_NOR:  single_result = ~(A | B);
            OP_DIVU: single_result = '1;
            OP_REMU: single_result = A;
            default: single_result = '0;
        endcase
    end

    // MSB-first steps: the multiplier bit and the dividend bit are both selected by the counter.
    assign mul_step  = {acc_reg[WIDTH-2:0], 1'b0} + (b_reg[cnt_reg] ? a_reg : '0);
    assign rem_shift = {acc_reg, a_reg[cnt_reg]};
    assign rem_sub   = rem_shift - {1'b0, b_reg};
    assign rem_ge    = (rem_shift >= {1'b0, b_reg});
    assign rem_step  = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_step  = {quo_reg[WIDTH-2:0], rem_ge};
    assign acc_step  = (op_reg == OP_MUL) ? mul_step : rem_step;

    always_comb begin
        iter_result = rem_step;
        if (op_reg == OP_MUL) begin
            iter_result = mul_step;
        end else if (op_reg == OP_DIVU) begin
            iter_result = quo_step;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = is_iter ? BUSY : DONE;
            BUSY: if (cnt_reg == '0) state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    if (accept) state_next = is_iter ? BUSY : DONE;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            quo_reg   <= '0;
            op_reg    <= '0;
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else if (accept) begin
            a_reg   <= A;
            b_reg   <= B;
            op_reg  <= ALUControl;
            acc_reg <= '0;
            quo_reg <= '0;
            cnt_reg <= is_iter ? SHW'(WIDTH-1) : '0;
            if (!is_iter) begin
                ALUResult <= single_result;
                Zero      <= (single_result == '0);
            end
        end else if (state_reg == BUSY) begin
            acc_reg <= acc_step;
            quo_reg <= quo_step;
            if (cnt_reg == '0) begin
                ALUResult <= iter_result;
                Zero      <= (iter_result == '0);
            end else begin
                cnt_reg <= cnt_reg - SHW'(1);
            end
        end
    end

endmodule
